// File: rtl/sparse_index_encoder_pkg.sv
// Shared types and helpers for the sparse index encoder.
// Used by sparse_index_encoder (optional SIE_POPCNT_EN popcount) and lsb_priority_enc.
package sie_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } sie_state_e;

  // Index width for a WIDTH-bit mask; a 2-bit mask still needs one index bit.
  function automatic int idx_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/sparse_index_encoder_lsb_priority_enc.sv
// Combinational lowest-set-bit encoder: index, any-bit-set and exactly-one-bit-set flags.
module lsb_priority_enc
  import sie_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IDX_W = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found,
  output logic             o_single
);

  logic [IDX_W-1:0] w_idx;

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    w_idx = {IDX_W{1'b0}};
    for (int k = WIDTH - 1; k >= 0; k--) begin
      w_idx = i_vec[k] ? IDX_W'(k) : w_idx;
    end
  end

  assign o_idx    = w_idx;
  assign o_found  = |i_vec;
  assign o_single = o_found && ((i_vec & (i_vec - WIDTH'(1))) == {WIDTH{1'b0}});

endmodule

// File: rtl/sparse_index_encoder.sv
// Sequential zero-skipping priority encoder: streams the index of every set mask bit, lowest first.
// Optional macro SIE_POPCNT_EN adds count_o, the popcount of the mask being scanned.
module sparse_index_encoder
  import sie_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IDX_W = idx_width(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             mask_valid_i,
  input  logic [WIDTH-1:0] mask_i,
  output logic             mask_ready_o,
  output logic             idx_valid_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             idx_last_o,
  input  logic             idx_ready_i,
  output logic             empty_o
`ifdef SIE_POPCNT_EN
  ,
  output logic [IDX_W:0]   count_o
`endif
);

  sie_state_e       r_state, w_next_state;
  logic [WIDTH-1:0] r_mask, w_next_mask;
  logic             r_empty, w_next_empty;
  logic [IDX_W-1:0] w_idx;
  logic             w_found;
  logic             w_single;
  logic             w_idx_hs;
  logic             w_mask_hs;

  lsb_priority_enc #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_enc (
    .i_vec    (r_mask),
    .o_idx    (w_idx),
    .o_found  (w_found),
    .o_single (w_single)
  );

  // Outputs decode only r_state/r_mask, so nothing from mask_i reaches idx_o.
  assign idx_valid_o  = (r_state == SCAN) && w_found;
  assign idx_o        = w_idx;
  assign idx_last_o   = idx_valid_o && w_single;
  assign empty_o      = r_empty;
  assign mask_ready_o = (r_state == IDLE) ? 1'b1 : (idx_last_o && idx_ready_i);
  assign w_idx_hs     = idx_valid_o && idx_ready_i;
  assign w_mask_hs    = mask_valid_i && mask_ready_o;

  // Next-state: retire the reported bit, then let an accepted mask override.
  always_comb begin
    w_next_state = r_state;
    w_next_mask  = r_mask;
    w_next_empty = 1'b0;
    if (w_idx_hs) begin
      w_next_mask  = r_mask & (r_mask - WIDTH'(1));
      w_next_state = idx_last_o ? IDLE : SCAN;
    end else begin
      w_next_mask  = r_mask;
    end
    if (w_mask_hs) begin
      if (mask_i != {WIDTH{1'b0}}) begin
        w_next_mask  = mask_i;
        w_next_state = SCAN;
      end else begin
        w_next_mask  = {WIDTH{1'b0}};
        w_next_state = IDLE;
        w_next_empty = 1'b1;
      end
    end else begin
      w_next_empty = 1'b0;
    end
  end

  // State, mask and empty-pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_mask  <= {WIDTH{1'b0}};
      r_empty <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_mask  <= w_next_mask;
      r_empty <= w_next_empty;
    end
  end

`ifdef SIE_POPCNT_EN
  logic [IDX_W:0] r_count;
  logic [IDX_W:0] w_popcnt;

  // Population count of the incoming mask, captured only on acceptance.
  always_comb begin
    w_popcnt = {(IDX_W + 1){1'b0}};
    for (int k = 0; k < WIDTH; k++) begin
      w_popcnt = w_popcnt + {{IDX_W{1'b0}}, mask_i[k]};
    end
  end

  // Count register; a zero mask yields a popcount of zero naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= {(IDX_W + 1){1'b0}};
    end else if (w_mask_hs) begin
      r_count <= w_popcnt;
    end else begin
      r_count <= r_count;
    end
  end

  assign count_o = r_count;
`endif

endmodule
